// File: rtl/xcha0s_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and sequencer state encoding.
package xcha0s_pkg;
    localparam int ALU_W = 16;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOT = 5'd5;
    localparam logic [4:0] ALU_SHL = 5'd6;
    localparam logic [4:0] ALU_SHR = 5'd7;
    localparam logic [4:0] ALU_ASR = 5'd8;
    localparam logic [4:0] ALU_ROL = 5'd9;
    localparam logic [4:0] ALU_ROR = 5'd10;
    localparam logic [4:0] ALU_ADC = 5'd11;
    localparam logic [4:0] ALU_SBC = 5'd12;
    localparam logic [4:0] ALU_CMP = 5'd13;
    localparam logic [4:0] ALU_TST = 5'd14;
    localparam logic [4:0] ALU_MOV = 5'd15;
    localparam logic [4:0] ALU_MUL = 5'd16;
    localparam logic [4:0] ALU_DIV = 5'd17;
    localparam logic [4:0] ALU_MOD = 5'd18;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } alu_state_e;
endpackage

// File: rtl/muldiv_seq.sv
// W-step sequencer: LSB-first shift-add multiplier or restoring divider sharing one hi/lo register pair.
module muldiv_seq
    import xcha0s_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic         is_div,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         fin
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, addend;
    logic [CW-1:0] cnt_q;
    logic          div_q, busy_q;
    logic [W:0]    sum, rsh, diff;

    // Outputs expose the post-step values so the final step's answer is registered on the same edge.
    always_comb begin
        addend = lo_q[0] ? b_q : '0;
        sum    = {1'b0, hi_q} + {1'b0, addend};
        rsh    = {hi_q, lo_q[W-1]};
        diff   = rsh - {1'b0, b_q};
        if (div_q) begin
            hi_d = diff[W] ? rsh[W-1:0] : diff[W-1:0];
            lo_d = {lo_q[W-2:0], ~diff[W]};
        end else begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            div_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (go) begin
            hi_q   <= '0;
            lo_q   <= A;
            b_q    <= B;
            div_q  <= is_div;
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) busy_q <= 1'b0;
        end
    end

    assign fin = busy_q && (cnt_q == LAST);
    assign lo  = lo_d;
    assign hi  = hi_d;
    assign quo = lo_d;
    assign rem = hi_d;
endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: single-cycle datapath plus optional sequential MUL/DIV/MOD.
// Define ALU_MULDIV_EN to build the multi-cycle path; otherwise codes 16..18 are illegal.
module alu_unit
    import xcha0s_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   opsel,
    input  logic [W-1:0] srcA,
    input  logic [W-1:0] srcB,
    input  logic         carry_in,
    output logic [W-1:0] result,
    output logic [3:0]   flags,
    output logic         ready,
    output logic         done
);
    localparam int SW = $clog2(W);

    alu_state_e     state_q;
    logic [4:0]     op_q;
    logic [SW-1:0]  amt;
    logic [W:0]     add_r, sub_r, shl_r, shr_r, asr_r;
    logic [2*W-1:0] rol_r, ror_r;
    logic [W-1:0]   alu_res, md_res, md_lo, md_hi, md_quo, md_rem;
    logic [3:0]     alu_flg, md_flg;
    logic           ci, bi, alu_c, alu_v, wr_res, legal, is_md, md_fin, md_ov;

`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;

    muldiv_seq #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .go     (start && is_md && (state_q != BUSY)),
        .is_div (opsel != ALU_MUL),
        .A      (srcA),
        .B      (srcB),
        .lo     (md_lo),
        .hi     (md_hi),
        .quo    (md_quo),
        .rem    (md_rem),
        .fin    (md_fin)
    );
`else
    localparam bit MD_EN = 1'b0;

    assign md_lo  = '0;
    assign md_hi  = '0;
    assign md_quo = '0;
    assign md_rem = '0;
    assign md_fin = 1'b0;
`endif

    always_comb begin
        amt   = srcB[SW-1:0];
        ci    = (opsel == ALU_ADC) & carry_in;
        bi    = (opsel == ALU_SBC) & ~carry_in;
        add_r = {1'b0, srcA} + {1'b0, srcB} + {{W{1'b0}}, ci};
        sub_r = {1'b0, srcA} - {1'b0, srcB} - {{W{1'b0}}, bi};
        shl_r = {1'b0, srcA} << amt;
        shr_r = {srcA, 1'b0} >> amt;
        asr_r = $signed({srcA, 1'b0}) >>> amt;
        rol_r = {srcA, srcA} << amt;
        ror_r = {srcA, srcA} >> amt;

        // Illegal codes clear the result and leave the flag register alone.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        wr_res  = 1'b1;
        legal   = 1'b1;
        is_md   = 1'b0;
        case (opsel)
            ALU_ADD, ALU_ADC: begin
                alu_res = add_r[W-1:0];
                alu_c   = add_r[W];
                alu_v   = (srcA[W-1] == srcB[W-1]) && (add_r[W-1] != srcA[W-1]);
            end
            ALU_SUB, ALU_SBC, ALU_CMP: begin
                alu_res = sub_r[W-1:0];
                alu_c   = ~sub_r[W];
                alu_v   = (srcA[W-1] != srcB[W-1]) && (sub_r[W-1] != srcA[W-1]);
                wr_res  = (opsel != ALU_CMP);
            end
            ALU_AND, ALU_TST: begin
                alu_res = srcA & srcB;
                wr_res  = (opsel != ALU_TST);
            end
            ALU_OR:  alu_res = srcA | srcB;
            ALU_XOR: alu_res = srcA ^ srcB;
            ALU_NOT: alu_res = ~srcA;
            ALU_MOV: alu_res = srcB;
            ALU_SHL: {alu_c, alu_res} = shl_r;
            ALU_SHR: {alu_res, alu_c} = shr_r;
            ALU_ASR: {alu_res, alu_c} = asr_r;
            ALU_ROL: begin
                alu_res = rol_r[2*W-1:W];
                alu_c   = (amt != '0) & alu_res[0];
            end
            ALU_ROR: begin
                alu_res = ror_r[W-1:0];
                alu_c   = (amt != '0) & alu_res[W-1];
            end
            ALU_MUL, ALU_DIV, ALU_MOD: begin
                if (MD_EN) begin
                    // Divide by zero short-circuits to a single-cycle saturated answer.
                    is_md   = (opsel == ALU_MUL) || (srcB != '0);
                    alu_res = (opsel == ALU_DIV) ? '1 : srcA;
                    alu_v   = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        alu_flg         = '0;
        alu_flg[FLAG_Z] = (alu_res == '0);
        alu_flg[FLAG_N] = alu_res[W-1];
        alu_flg[FLAG_C] = alu_c;
        alu_flg[FLAG_V] = alu_v;

        md_res = md_lo;
        if (op_q == ALU_DIV)      md_res = md_quo;
        else if (op_q == ALU_MOD) md_res = md_rem;
        md_ov          = (op_q == ALU_MUL) && (md_hi != '0);
        md_flg         = '0;
        md_flg[FLAG_Z] = (md_res == '0);
        md_flg[FLAG_N] = md_res[W-1];
        md_flg[FLAG_C] = md_ov;
        md_flg[FLAG_V] = md_ov;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= ALU_ADD;
            result  <= '0;
            flags   <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                BUSY: begin
                    if (md_fin) begin
                        state_q <= FINISH;
                        result  <= md_res;
                        flags   <= md_flg;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    // FINISH accepts a new issue exactly like IDLE.
                    state_q <= IDLE;
                    if (start) begin
                        if (is_md) begin
                            state_q <= BUSY;
                            op_q    <= opsel;
                            ready   <= 1'b0;
                        end else begin
                            done <= 1'b1;
                            if (wr_res) result <= alu_res;
                            if (legal)  flags  <= alu_flg;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: driver pushes model expectations, negedge monitor pops on done.
module tb_alu_unit;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, carry_in = 1'b0;
    logic [4:0]  opsel = '0;
    logic [15:0] srcA = '0, srcB = '0;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        ready, done;

    alu_unit #(.W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .opsel(opsel), .srcA(srcA), .srcB(srcB),
        .carry_in(carry_in), .result(result), .flags(flags), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          due;
        logic [4:0]  op;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0, n_fail = 0;
    int          busy_start = -1000;
    bit          mon_en = 1'b0;
    logic [15:0] m_res = '0;
    logic [3:0]  m_flg = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic from the operation definitions.
    task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, output logic [15:0] r, output logic [3:0] f,
                         output bit multi);
        longint u;
        int sa, sb, sr, n, cv;
        bit c, v, wr, lg;
        logic [15:0] val;
        sa = $signed(a); sb = $signed(b); n = int'(b[3:0]);
        c = 0; v = 0; wr = 1; lg = 1; multi = 0; val = '0;
        case (op)
            0, 11: begin
                cv = (op == 11 && ci) ? 1 : 0;
                u = longint'(a) + longint'(b) + longint'(cv);
                val = u[15:0]; c = u > 65535;
                sr = sa + sb + cv; v = sr > 32767 || sr < -32768;
            end
            1, 12, 13: begin
                cv = (op == 12 && !ci) ? 1 : 0;
                u = longint'(a) - longint'(b) - longint'(cv);
                val = u[15:0]; c = u >= 0;
                sr = sa - sb - cv; v = sr > 32767 || sr < -32768;
                wr = (op != 13);
            end
            2, 14: begin val = a & b; wr = (op != 14); end
            3: val = a | b;
            4: val = a ^ b;
            5: val = ~a;
            15: val = b;
            6: begin u = longint'(a) << n; val = u[15:0]; c = (n != 0) && u[16]; end
            7: begin val = a >> n; c = (n != 0) && a[(n + 15) % 16]; end
            8: begin val = 16'(sa >>> n); c = (n != 0) && a[(n + 15) % 16]; end
            9: begin val = a; for (int i = 0; i < n; i++) begin c = val[15]; val = {val[14:0], val[15]}; end end
            10: begin val = a; for (int i = 0; i < n; i++) begin c = val[0]; val = {val[0], val[15:1]}; end end
            16: if (MD) begin
                u = longint'(a) * longint'(b);
                val = u[15:0]; c = (u >> 16) != 0; v = c; multi = 1;
            end else lg = 0;
            17, 18: if (MD) begin
                if (b == 0) begin val = (op == 17) ? 16'hFFFF : a; v = 1; end
                else begin val = (op == 17) ? a / b : a % b; multi = 1; end
            end else lg = 0;
            default: lg = 0;
        endcase
        f = lg ? {val == 16'h0, val[15], c, v} : m_flg;
        r = !lg ? 16'h0 : (wr ? val : m_res);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input int abort_at = -1);
        logic [15:0] r;
        logic [3:0]  f;
        bit          multi, aborted;
        exp_t        e;
        @(negedge clk);
        start = 1'b1; opsel = op; srcA = a; srcB = b; carry_in = ci;
        model(op, a, b, ci, r, f, multi);
        e.res = r; e.flg = f; e.op = op;
        e.due = multi ? cyc + 17 : cyc + 1;
        q.push_back(e);
        m_res = r; m_flg = f;
        if (multi) begin
            busy_start = cyc + 1;
            aborted = 0;
            // Random (ignored) issue attempts while the unit is busy.
            for (int i = 0; i < 16 && !aborted; i++) begin
                @(negedge clk);
                if (i == abort_at) begin
                    start = 1'b0; rst = 1'b0;
                    @(posedge clk);
                    #1;
                    q.delete(); m_res = '0; m_flg = '0; busy_start = -1000;
                    @(negedge clk);
                    chk("abort_result", 32'(result), 32'h0);
                    chk("abort_flags", 32'(flags), 32'h0);
                    chk("abort_ready", 32'(ready), 32'h1);
                    chk("abort_done", 32'(done), 32'h0);
                    rst = 1'b1;
                    aborted = 1;
                end else begin
                    start = 1'($urandom); opsel = 5'($urandom);
                    srcA = 16'($urandom); srcB = 16'($urandom); carry_in = 1'($urandom);
                end
            end
        end
    endtask

    // Monitor: done must coincide with the head expectation's due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_done;
            exp_t e;
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            chk("ready", 32'(ready), 32'(!(cyc >= busy_start && cyc < busy_start + 16)));
            chk("done", 32'(done), 32'(exp_done));
            if (q.size() > 0 && (done || q[0].due <= cyc)) begin
                e = q.pop_front();
                if (done) begin
                    chk($sformatf("result op%0d", e.op), 32'(result), 32'(e.res));
                    chk($sformatf("flags op%0d", e.op), 32'(flags), 32'(e.flg));
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;

        issue(5'd0, 16'h7FFF, 16'h0001, 1'b0);
        issue(5'd1, 16'h0005, 16'h0005, 1'b0);
        issue(5'd15, 16'h0000, 16'h1234, 1'b0);
        issue(5'd13, 16'h1234, 16'h0001, 1'b0);
        issue(5'd6, 16'h8001, 16'h0001, 1'b0);
        issue(5'd11, 16'hFFFF, 16'h0000, 1'b1);
        issue(5'd12, 16'h8000, 16'h0000, 1'b0);
        issue(5'd9, 16'h8001, 16'h0000, 1'b0);
        issue(5'd10, 16'h0003, 16'h0004, 1'b0);
        issue(5'd8, 16'h8000, 16'h000F, 1'b0);
        issue(5'd16, 16'h0100, 16'h0100, 1'b0);
        issue(5'd17, 16'd100, 16'd7, 1'b0);
        issue(5'd18, 16'd100, 16'd7, 1'b0);
        issue(5'd17, 16'h1234, 16'h0000, 1'b0);
        issue(5'd18, 16'h1234, 16'h0000, 1'b0);
        idle();
        issue(5'd17, 16'hBEEF, 16'h0013, 1'b0, 7);
        issue(5'd25, 16'h1111, 16'h2222, 1'b0);
        idle();

        for (int k = 0; k < 250; k++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            issue(5'($urandom_range(0, 31)), 16'($urandom), b, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end

        repeat (20) idle();
        chk("drain", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_unit.md
# alu_unit

Execution unit that responds to the control unit's `opsel`/`ready` interface: registers a 16-bit result and 4-bit flags for each issued operation. Logic/add/shift ops finish in one cycle. Multiply/divide run as 16-step sequential iterations, and `ready` drops while they run. Sits between the operand muxes (srcA/srcB) and the X/Y/ACC writeback and flag register.

## Interface
- `W`, 16, operand/result width; the multi-cycle iteration count equals `W`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  issue strobe; accepted only when `ready`=1.
- `opsel`  in  5  operation code, sampled with `start`.
- `srcA`  in  W  operand A, sampled with `start`.
- `srcB`  in  W  operand B, sampled with `start`.
- `carry_in`  in  1  current C flag, used by ADC/SBC.
- `result`  out  W  registered result.
- `flags`  out  4  registered {Z,N,C,V} (bit3..bit0).
- `ready`  out  1  high = idle, can accept `start`.
- `done`  out  1  one-cycle pulse when `result`/`flags` update.

## Operation
- Codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5 (~A).
  - SHL=6, SHR=7, ASR=8, ROL=9, ROR=10.
  - ADC=11, SBC=12, CMP=13, TST=14, MOV=15 (B).
  - MUL=16, DIV=17, MOD=18.
  - 19..31 are illegal.
- Arithmetic is modulo 2^W.
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB/SBC/CMP: A−B(−!carry_in for SBC); C = no-borrow; V = signed overflow.
- Logic ops and MOV/NOT: C=0, V=0.
- Shifts/rotates use amount `srcB[3:0]`.
  - C = last bit shifted out; amount 0 gives C=0.
  - V=0.
- CMP/TST update flags only; `result` holds its previous value.
- Z = (result==0), N = result[W-1].
  - For CMP/TST, Z and N are taken from the internal difference/AND value.
- MUL (unsigned): `result` = low W bits; C = V = (high W bits ≠ 0).
- DIV/MOD (unsigned restoring): `result` = quotient / remainder; C=0, V=0.
- DIV/MOD with B=0: completes single-cycle.
  - DIV result = all-ones; MOD result = A.
  - V=1, C=0.
- Illegal code: single-cycle, `result`=0, flags unchanged, `done` pulses.
- FSM states IDLE, BUSY, FINISH:
  - IDLE → BUSY on `start` with MUL/DIV/MOD and B≠0 (division).
  - BUSY → FINISH when the step counter reaches W−1.
  - FINISH → IDLE unconditionally.
- `start` while `ready`=0 is ignored. Operands may change freely after acceptance; they are latched internally.

## Timing
- Reset values:
  - `result`=0, `flags`=0.
  - `ready`=1, `done`=0.
  - FSM in IDLE, counter cleared.
- Single-cycle op: `start` at edge T → `result`/`flags` valid and `done`=1 during T+1. `ready` stays 1, so back-to-back issue every cycle is legal.
- Multi-cycle op: `start` at T.
  - `ready`=0 from T+1 through T+W.
  - Iterations occur at edges T+1..T+W.
  - `result`/`flags`/`done`=1 and `ready`=1 in cycle T+W+1 (latency W+1 = 17).
  - A new `start` is accepted in that same cycle.
- `done` is never high on two consecutive cycles for one operation. It is low whenever `ready`=0.
- Reset asserted mid-BUSY (sampled on an edge) → next cycle fully at reset values. The partial result is discarded and `done` is not pulsed.

## Configuration
- `ALU_MULDIV_EN` defined: MUL/DIV/MOD and the BUSY/FINISH path are present as described.
- `ALU_MULDIV_EN` undefined:
  - Codes 16..18 behave as illegal codes.
  - No sequential datapath is instantiated.
  - `ready` is constant 1 after reset.

## Structure
- Shared package `xcha0s_pkg` holds:
  - opcode localparams (ALU_ADD … ALU_MOD);
  - flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0);
  - the FSM state encoding.
- Sub-module `muldiv_seq`: W-step shift-add multiplier / restoring divider.
  - Interface: `go`, `is_div`, A, B.
  - Outputs: `lo`/`hi` (product) or `quo`/`rem`, plus `fin`.
  - Instantiated only under `ALU_MULDIV_EN`.
- Top-level `alu_unit` contains the combinational single-cycle datapath, the FSM and the output registers.

## Test plan
- Reset with `rst`=0 for 2 cycles → `result`=0, `flags`=0, `ready`=1, `done`=0.
- Single-cycle arithmetic:
  - ADD 0x7FFF+0x0001 → result 0x8000, flags N=1, V=1, C=0, Z=0; `done` one cycle after `start`.
  - SUB 0x0005−0x0005 → Z=1, C=1.
- CMP after a MOV 0x1234 → `result` stays 0x1234 while flags update. Then SHL A=0x8001, amount 1 → result 0x0002, C=1.
- MUL 0x0100×0x0100:
  - `ready` low for 16 cycles; result 0x0000 with C=1, V=1 at cycle 17.
  - `start` pulses during busy are ignored.
- Division:
  - DIV 100/7 → 14 and MOD 100/7 → 2, each with latency 17.
  - DIV 0x1234/0 → 0xFFFF, V=1 after 1 cycle.
- Reset asserted at busy cycle 8 of a DIV → reset values next cycle, no `done`. Illegal code 25 → result 0, flags unchanged, `done` pulses.
- With `ALU_MULDIV_EN` undefined: MUL → 1 cycle, result 0.
